// File: rtl/wb_pkg.sv
// Shared constants, buffered entry record and base-priority helper for the
// writeback arbiter and its per-source FIFOs.
package wb_pkg;
  localparam int NUM_SRC = 3;
  localparam int SRC_ALU = 0;
  localparam int SRC_FP  = 1;
  localparam int SRC_LD  = 2;
  localparam int DEST_W  = 5;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic              isFloat;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot pick of the highest base-priority candidate: load, then ALU, then FP.
  function automatic logic [NUM_SRC-1:0] pickBase(input logic [NUM_SRC-1:0] candidates);
    logic [NUM_SRC-1:0] oneHot;
    oneHot = '0;
    if (candidates[SRC_LD])       oneHot[SRC_LD]  = 1'b1;
    else if (candidates[SRC_ALU]) oneHot[SRC_ALU] = 1'b1;
    else if (candidates[SRC_FP])  oneHot[SRC_FP]  = 1'b1;
    return oneHot;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback buffer: power-of-two circular FIFO whose full flag
// depends only on its own occupancy.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t pushEntry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush, doPop;

  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign head_o  = mem_q[rdPtr_q];

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushEntry_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Three-source register-file writeback arbiter: per-source FIFOs, fixed
// priority with starvation urgency, and a registered write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DEST_W-1:0] src_dest,
  input  logic [NUM_SRC-1:0]        src_float,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      reg_write,
  output logic                      float_write,
  output logic [DEST_W-1:0]         rd,
  output logic [DEST_W-1:0]         frd,
  output logic [DATA_W-1:0]         write_data,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t          pushEntry [NUM_SRC];
  wb_entry_t          head      [NUM_SRC];
  wb_entry_t          selEntry;
  logic [NUM_SRC-1:0] full, empty, nonEmpty, urgent, pick;
  logic [CNT_W-1:0]   starveCnt_q [NUM_SRC];
  logic [CNT_W-1:0]   starveCnt_d [NUM_SRC];

  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               regWrite_q, regWrite_d;
  logic               floatWrite_q, floatWrite_d;
  logic [DEST_W-1:0]  rd_q, rd_d;
  logic [DEST_W-1:0]  frd_q, frd_d;
  logic [DATA_W-1:0]  writeData_q, writeData_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    assign pushEntry[i] = '{dest:    src_dest[DEST_W*i +: DEST_W],
                            isFloat: src_float[i],
                            data:    src_data[DATA_W*i +: DATA_W]};

    wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (src_valid[i]),
      .pushEntry_i (pushEntry[i]),
      .pop_i       (pick[i]),
      .head_o      (head[i]),
      .full_o      (full[i]),
      .empty_o     (empty[i])
    );

    assign src_ready[i] = !full[i];
    assign nonEmpty[i]  = !empty[i];
    assign urgent[i]    = nonEmpty[i] && (starveCnt_q[i] == CNT_W'(STARVE_LIMIT));
  end

  // Urgent sources form a separate tier above everyone else; base order breaks ties.
  assign pick = (|urgent) ? pickBase(urgent) : pickBase(nonEmpty);

  always_comb begin
    selEntry = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick[i]) selEntry = head[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      starveCnt_d[i] = starveCnt_q[i];
      if (!nonEmpty[i] || pick[i])
        starveCnt_d[i] = '0;
      else if (starveCnt_q[i] != CNT_W'(STARVE_LIMIT))
        starveCnt_d[i] = starveCnt_q[i] + 1'b1;
    end
  end

  // Integer writes to register 0 are consumed and shown on grant but never enabled.
  always_comb begin
    grant_d      = '0;
    regWrite_d   = 1'b0;
    floatWrite_d = 1'b0;
    rd_d         = '0;
    frd_d        = '0;
    writeData_d  = '0;
    if (|pick) begin
      grant_d     = pick;
      writeData_d = selEntry.data;
      if (selEntry.isFloat) begin
        floatWrite_d = 1'b1;
        frd_d        = selEntry.dest;
      end else begin
        regWrite_d = (selEntry.dest != '0);
        rd_d       = selEntry.dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) starveCnt_q[i] <= '0;
      grant_q      <= '0;
      regWrite_q   <= 1'b0;
      floatWrite_q <= 1'b0;
      rd_q         <= '0;
      frd_q        <= '0;
      writeData_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) starveCnt_q[i] <= starveCnt_d[i];
      grant_q      <= grant_d;
      regWrite_q   <= regWrite_d;
      floatWrite_q <= floatWrite_d;
      rd_q         <= rd_d;
      frd_q        <= frd_d;
      writeData_q  <= writeData_d;
    end
  end

  assign grant       = grant_q;
  assign reg_write   = regWrite_q;
  assign float_write = floatWrite_q;
  assign rd          = rd_q;
  assign frd         = frd_q;
  assign write_data  = writeData_q;
  assign busy        = (|nonEmpty) || (|grant_q);
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int ORDER [3] = '{SRC_LD, SRC_ALU, SRC_FP};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_dest;
  logic [2:0]  src_float;
  logic [95:0] src_data;
  logic        reg_write, float_write;
  logic [4:0]  rd, frd;
  logic [31:0] write_data;
  logic [2:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_dest    (src_dest),
    .src_float   (src_float),
    .src_data    (src_data),
    .reg_write   (reg_write),
    .float_write (float_write),
    .rd          (rd),
    .frd         (frd),
    .write_data  (write_data),
    .grant       (grant),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]  dest;
    logic        fl;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        rstN;
    logic [2:0]  valid;
    logic [14:0] dest;
    logic [2:0]  fl;
    logic [95:0] data;
    logic [2:0]  eGrant;
    logic        eRw;
    logic        eFw;
    logic [4:0]  eRd;
    logic [4:0]  eFrd;
    logic [31:0] eData;
  } vec_t;

  ent_t        refQ [3][$];
  int          starve [3];
  logic [2:0]  expGrant;
  logic        expRw, expFw;
  logic [4:0]  expRd, expFrd;
  logic [31:0] expData;
  bit          synced = 1'b0;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: queues per source, winner from the urgent tier first, then base order.
  task automatic modelEdge();
    int   winner;
    int   preSize [3];
    ent_t e;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        refQ[i].delete();
        starve[i] = 0;
      end
      expGrant = '0; expRw = 1'b0; expFw = 1'b0;
      expRd = '0; expFrd = '0; expData = '0;
      return;
    end
    for (int i = 0; i < 3; i++) preSize[i] = refQ[i].size();
    winner = -1;
    for (int k = 0; k < 3; k++)
      if (winner < 0 && preSize[ORDER[k]] > 0 && starve[ORDER[k]] == LIMIT) winner = ORDER[k];
    for (int k = 0; k < 3; k++)
      if (winner < 0 && preSize[ORDER[k]] > 0) winner = ORDER[k];
    expGrant = '0; expRw = 1'b0; expFw = 1'b0;
    expRd = '0; expFrd = '0; expData = '0;
    if (winner >= 0) begin
      e = refQ[winner].pop_front();
      expGrant = 3'(1 << winner);
      expData  = e.data;
      if (e.fl) begin
        expFw  = 1'b1;
        expFrd = e.dest;
      end else begin
        expRw = (e.dest != 5'd0);
        expRd = e.dest;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (preSize[i] == 0 || i == winner) starve[i] = 0;
      else if (starve[i] < LIMIT) starve[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      if (src_valid[i] && preSize[i] < DEPTH) begin
        e.dest = src_dest[5*i +: 5];
        e.fl   = src_float[i];
        e.data = src_data[32*i +: 32];
        refQ[i].push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] v, input logic [14:0] d,
                               input logic [2:0] f, input logic [95:0] dat);
    logic [2:0] expReady;
    logic       expBusy;
    rst_n = r; src_valid = v; src_dest = d; src_float = f; src_data = dat;
    if (synced) begin
      expBusy = (expGrant != 3'b000);
      for (int i = 0; i < 3; i++) begin
        expReady[i] = (refQ[i].size() < DEPTH);
        if (refQ[i].size() > 0) expBusy = 1'b1;
      end
      checkOutput("src_ready", 32'(src_ready), 32'(expReady));
      checkOutput("busy", 32'(busy), 32'(expBusy));
    end
    modelEdge();
    @(posedge clk);
    #1;
    if (!r) synced = 1'b1;
    if (synced) begin
      checkOutput("grant", 32'(grant), 32'(expGrant));
      checkOutput("reg_write", 32'(reg_write), 32'(expRw));
      checkOutput("float_write", 32'(float_write), 32'(expFw));
      checkOutput("rd", 32'(rd), 32'(expRd));
      checkOutput("frd", 32'(frd), 32'(expFrd));
      checkOutput("write_data", write_data, expData);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 3'b000, 15'd0, 3'b000, 96'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          firstTick;
    int          fpSeen [$];
    logic [95:0] rdata;

    vecs[0]  = '{1'b0, 3'b000, 15'd0, 3'b000, 96'd0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[1]  = '{1'b1, 3'b001, {10'd0, 5'd5}, 3'b000, {64'd0, 32'h0000_00AA},
                 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[2]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b001, 1'b1, 1'b0, 5'd5, 5'd0, 32'hAA};
    vecs[3]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[4]  = '{1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, 3'b010, {32'h33, 32'h22, 32'h11},
                 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[5]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b100, 1'b1, 1'b0, 5'd3, 5'd0, 32'h33};
    vecs[6]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b001, 1'b1, 1'b0, 5'd1, 5'd0, 32'h11};
    vecs[7]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b010, 1'b0, 1'b1, 5'd0, 5'd2, 32'h22};
    vecs[8]  = '{1'b1, 3'b001, 15'd0, 3'b000, {64'd0, 32'hFFFF_FFFF},
                 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[9]  = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b001, 1'b0, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 3'b100, 15'd0, 3'b100, {32'h5, 64'd0},
                 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
    vecs[11] = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b100, 1'b0, 1'b1, 5'd0, 5'd0, 32'h5};
    vecs[12] = '{1'b1, 3'b000, 15'd0, 3'b000, 96'd0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};

    for (int n = 0; n < 13; n++) begin
      applyStimulus(vecs[n].rstN, vecs[n].valid, vecs[n].dest, vecs[n].fl, vecs[n].data);
      checkOutput($sformatf("vec%0d_grant", n), 32'(grant), 32'(vecs[n].eGrant));
      checkOutput($sformatf("vec%0d_reg_write", n), 32'(reg_write), 32'(vecs[n].eRw));
      checkOutput($sformatf("vec%0d_float_write", n), 32'(float_write), 32'(vecs[n].eFw));
      checkOutput($sformatf("vec%0d_rd", n), 32'(rd), 32'(vecs[n].eRd));
      checkOutput($sformatf("vec%0d_frd", n), 32'(frd), 32'(vecs[n].eFrd));
      checkOutput($sformatf("vec%0d_write_data", n), write_data, vecs[n].eData);
    end

    // FP fills while load/ALU keep winning; the third FP offer must be dropped.
    applyStimulus(1'b1, 3'b111, {5'd20, 5'd7, 5'd10}, 3'b010, {32'hC1, 32'h71, 32'hA1});
    applyStimulus(1'b1, 3'b111, {5'd21, 5'd8, 5'd11}, 3'b010, {32'hC2, 32'h81, 32'hA2});
    checkOutput("fp_full_ready", 32'(src_ready[SRC_FP]), 32'd0);
    applyStimulus(1'b1, 3'b111, {5'd22, 5'd9, 5'd12}, 3'b010, {32'hC3, 32'h91, 32'hA3});
    for (int k = 0; k < 16; k++) begin
      idle(1);
      if (grant == 3'b010 && float_write) fpSeen.push_back(int'(frd));
    end
    checkOutput("fp_drain_count", 32'(fpSeen.size()), 32'd2);
    if (fpSeen.size() == 2) begin
      checkOutput("fp_drain_first", 32'(fpSeen[0]), 32'd7);
      checkOutput("fp_drain_second", 32'(fpSeen[1]), 32'd8);
    end

    // Starvation bound: FP head must win within LIMIT+1 cycles of reaching the head.
    applyStimulus(1'b0, 3'b000, 15'd0, 3'b000, 96'd0);
    applyStimulus(1'b1, 3'b111, {5'd3, 5'd4, 5'd1}, 3'b010, {32'h3, 32'h4, 32'h1});
    firstTick = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 3'b101, {5'd3, 5'd0, 5'd1}, 3'b000, {32'h3, 32'h0, 32'h1});
      if (firstTick < 0 && grant == 3'b010) firstTick = k;
    end
    checks++;
    if (firstTick < 0 || firstTick > LIMIT + 2) begin
      failures++;
      $display("[TB] FAIL fp_starve_tick actual=%0d required<=%0d", firstTick, LIMIT + 2);
    end

    // Reset with loaded FIFOs discards everything, including the in-flight write.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 3'b111, {5'd9, 5'd8, 5'd7}, 3'b010, {32'h9, 32'h8, 32'h7});
    applyStimulus(1'b0, 3'b111, {5'd9, 5'd8, 5'd7}, 3'b010, {32'h9, 32'h8, 32'h7});
    checkOutput("rst_ready", 32'(src_ready), 32'h7);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_float_write", 32'(float_write), 32'd0);

    for (int k = 0; k < 400; k++) begin
      rdata = {$urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 63) != 0), 3'($urandom_range(0, 7)), 15'($urandom),
                    3'($urandom_range(0, 7)), rdata);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
